// File: rtl/bus_pkg.sv
// Shared types and defaults for the serial bus master port.
// Holds the FSM state encoding, the default widths and the rw encoding.
package bus_pkg;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    SEL,
    ADDR,
    WDATA,
    RWAIT,
    DONE
  } bus_state_t;

  localparam int DEF_ADDR_W  = 12;
  localparam int DEF_DATA_W  = 8;
  localparam int DEF_SLV_W   = 2;
  localparam int DEF_TIMEOUT = 255;

  localparam logic RW_WRITE = 1'b1;
  localparam logic RW_READ  = 1'b0;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // Width of a counter that must hold 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/bus_shift_reg.sv
// Parallel-load shift register, LSB leaves first and new bits enter at the MSB,
// so after WIDTH shifts the first serial bit in sits at bit 0.
module bus_shift_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             load,
  input  logic             shift,
  input  logic             serial_in,
  input  logic [WIDTH-1:0] load_data,
  output logic [WIDTH-1:0] data
);

  logic [WIDTH-1:0] data_reg;
  logic [WIDTH-1:0] shifted;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_shift
      if (gi == WIDTH - 1) begin : g_msb
        assign shifted[gi] = serial_in;
      end else begin : g_body
        assign shifted[gi] = data_reg[gi+1];
      end
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_reg <= '0;
    end else if (clear) begin
      data_reg <= '0;
    end else if (load) begin
      data_reg <= load_data;
    end else if (shift) begin
      data_reg <= shifted;
    end
  end

  assign data = data_reg;

endmodule

// File: rtl/bus_master_port.sv
// Master-side serial bus port: requests the arbiter, sends slave select, address
// and write data, collects read replies, restarts on preemption, aborts on timeout.
module bus_master_port
  import bus_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int SLV_W   = DEF_SLV_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              rw,
  input  logic [SLV_W-1:0]  slave_id,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              ready,
  output logic              done,
  output logic              error,
  output logic [DATA_W-1:0] rdata,
  output logic              request,
  input  logic              grant,
  output logic              slave_select,
  output logic              bus_out,
  output logic              bus_valid,
  output logic              bus_rw,
  input  logic              bus_in,
  input  logic              bus_in_valid
);

  localparam int TX_W       = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
  localparam int BIT_CNT_W  = cnt_width(max3(ADDR_W, DATA_W, SLV_W + 1));
  localparam int WAIT_CNT_W = cnt_width(TIMEOUT);

  localparam logic [BIT_CNT_W-1:0]  SEL_LAST  = BIT_CNT_W'(SLV_W);
  localparam logic [BIT_CNT_W-1:0]  ADDR_LAST = BIT_CNT_W'(ADDR_W - 1);
  localparam logic [BIT_CNT_W-1:0]  DATA_LAST = BIT_CNT_W'(DATA_W - 1);
  localparam logic [WAIT_CNT_W-1:0] WAIT_LAST = WAIT_CNT_W'(TIMEOUT - 1);

  bus_state_t state_reg;
  bus_state_t state_next;
  logic       timeout_hit;

  logic [BIT_CNT_W-1:0]  bit_cnt_reg;
  logic [WAIT_CNT_W-1:0] wait_cnt_reg;

  logic              rw_reg;
  logic [SLV_W-1:0]  slave_id_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [DATA_W-1:0] wdata_reg;
  logic [DATA_W-1:0] rdata_reg;
  logic              error_reg;

  logic            tx_load;
  logic            tx_shift;
  logic            tx_clear;
  logic [TX_W-1:0] tx_load_data;
  logic [TX_W-1:0] tx_q;

  logic              rx_clear;
  logic              rx_shift;
  logic [DATA_W-1:0] rx_q;

  logic [SLV_W:0] sel_frame;
  logic [SLV_W:0] sel_hit;
  logic           sel_bit;
  logic           unused_shift_bits;

  // ---------------- state register ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // ---------------- next-state logic ----------------
  always_comb begin
    state_next  = state_reg;
    timeout_hit = 1'b0;
    unique case (state_reg)
      IDLE: begin
        if (start) state_next = REQ;
      end
      REQ: begin
        if (grant) begin
          state_next = SEL;
        end else if (wait_cnt_reg == WAIT_LAST) begin
          state_next  = IDLE;
          timeout_hit = 1'b1;
        end
      end
      SEL: begin
        if (!grant) state_next = REQ;
        else if (bit_cnt_reg == SEL_LAST) state_next = ADDR;
      end
      ADDR: begin
        if (!grant) state_next = REQ;
        else if (bit_cnt_reg == ADDR_LAST) state_next = (rw_reg == RW_WRITE) ? WDATA : RWAIT;
      end
      WDATA: begin
        if (!grant) state_next = REQ;
        else if (bit_cnt_reg == DATA_LAST) state_next = DONE;
      end
      RWAIT: begin
        // Preemption outranks both a completing bit and a reply timeout.
        if (!grant) begin
          state_next = REQ;
        end else if (bus_in_valid) begin
          if (bit_cnt_reg == DATA_LAST) state_next = DONE;
        end else if (wait_cnt_reg == WAIT_LAST) begin
          state_next  = IDLE;
          timeout_hit = 1'b1;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // ---------------- output logic ----------------
  always_comb begin
    ready        = 1'b0;
    request      = 1'b0;
    done         = 1'b0;
    slave_select = 1'b0;
    bus_valid    = 1'b0;
    bus_out      = 1'b0;
    bus_rw       = 1'b0;
    unique case (state_reg)
      IDLE: ready = 1'b1;
      REQ:  request = 1'b1;
      SEL: begin
        request      = 1'b1;
        slave_select = grant & sel_bit;
      end
      ADDR, WDATA: begin
        // Bus drive is gated by grant so nothing leaks out during preemption.
        request   = 1'b1;
        bus_valid = grant;
        bus_out   = grant & tx_q[0];
        bus_rw    = grant & rw_reg;
      end
      RWAIT: request = 1'b1;
      DONE:  done = 1'b1;
      default: ready = 1'b0;
    endcase
  end

  assign error = error_reg;
  assign rdata = rdata_reg;

  // Slave-select frame: start bit at position 0, then slave_id LSB first.
  assign sel_frame = {slave_id_reg, 1'b1};

  genvar gi;
  generate
    for (gi = 0; gi <= SLV_W; gi++) begin : g_sel
      assign sel_hit[gi] = (bit_cnt_reg == BIT_CNT_W'(gi)) & sel_frame[gi];
    end
  endgenerate

  assign sel_bit = |sel_hit;

  // ---------------- counters ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bit_cnt_reg  <= '0;
      wait_cnt_reg <= '0;
    end else if (state_next != state_reg) begin
      bit_cnt_reg  <= '0;
      wait_cnt_reg <= '0;
    end else begin
      unique case (state_reg)
        SEL, ADDR, WDATA: bit_cnt_reg <= bit_cnt_reg + BIT_CNT_W'(1);
        REQ: wait_cnt_reg <= wait_cnt_reg + WAIT_CNT_W'(1);
        RWAIT: begin
          if (bus_in_valid) begin
            bit_cnt_reg  <= bit_cnt_reg + BIT_CNT_W'(1);
            wait_cnt_reg <= '0;
          end else begin
            wait_cnt_reg <= wait_cnt_reg + WAIT_CNT_W'(1);
          end
        end
        default: begin
          bit_cnt_reg  <= bit_cnt_reg;
          wait_cnt_reg <= wait_cnt_reg;
        end
      endcase
    end
  end

  // ---------------- command capture and result registers ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rw_reg       <= 1'b0;
      slave_id_reg <= '0;
      addr_reg     <= '0;
      wdata_reg    <= '0;
      rdata_reg    <= '0;
      error_reg    <= 1'b0;
    end else begin
      if (state_reg == IDLE && start) begin
        rw_reg       <= rw;
        slave_id_reg <= slave_id;
        addr_reg     <= addr;
        wdata_reg    <= wdata;
      end
      if (state_reg == RWAIT && state_next == DONE) begin
        rdata_reg <= {bus_in, rx_q[DATA_W-1:1]};
      end
      error_reg <= timeout_hit;
    end
  end

  // ---------------- shift-path control ----------------
  always_comb begin
    tx_load      = ((state_reg == SEL) && (state_next == ADDR)) ||
                   ((state_reg == ADDR) && (state_next == WDATA));
    tx_load_data = (state_reg == ADDR) ? TX_W'(wdata_reg) : TX_W'(addr_reg);
    tx_shift     = ((state_reg == ADDR) || (state_reg == WDATA)) && (state_next == state_reg);
    tx_clear     = (state_next == REQ) && (state_reg != REQ);
    rx_clear     = tx_clear;
    rx_shift     = (state_reg == RWAIT) && grant && bus_in_valid;
  end

  bus_shift_reg #(
    .WIDTH(TX_W)
  ) u_tx_shift (
    .clk       (clk),
    .reset     (reset),
    .clear     (tx_clear),
    .load      (tx_load),
    .shift     (tx_shift),
    .serial_in (1'b0),
    .load_data (tx_load_data),
    .data      (tx_q)
  );

  bus_shift_reg #(
    .WIDTH(DATA_W)
  ) u_rx_shift (
    .clk       (clk),
    .reset     (reset),
    .clear     (rx_clear),
    .load      (1'b0),
    .shift     (rx_shift),
    .serial_in (bus_in),
    .load_data ('0),
    .data      (rx_q)
  );

  // Only the TX LSB is driven out, and the final RX bit bypasses the register.
  assign unused_shift_bits = ^{tx_q[TX_W-1:1], rx_q[0]};

endmodule

// File: tb/tb_bus_master_port.sv
// Scenario bench for bus_master_port: write, read with gaps, grant timeout,
// preemption restart, read timeout and asynchronous reset.
module tb_bus_master_port;
  import bus_pkg::*;

  localparam int ADDR_W  = 12;
  localparam int DATA_W  = 8;
  localparam int SLV_W   = 2;
  localparam int TIMEOUT = 255;
  localparam int WR_LAT  = SLV_W + 1 + ADDR_W + DATA_W + 1;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic              rw;
  logic [SLV_W-1:0]  slave_id;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              ready;
  logic              done;
  logic              error;
  logic [DATA_W-1:0] rdata;
  logic              request;
  logic              grant;
  logic              slave_select;
  logic              bus_out;
  logic              bus_valid;
  logic              bus_rw;
  logic              bus_in;
  logic              bus_in_valid;

  int errors = 0;
  int checks = 0;

  bit                exp_sel_q[$];
  bit                exp_bus_q[$];
  logic [DATA_W-1:0] exp_rdata_q[$];
  logic [DATA_W-1:0] last_rdata;

  bus_master_port #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .SLV_W  (SLV_W),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .rw          (rw),
    .slave_id    (slave_id),
    .addr        (addr),
    .wdata       (wdata),
    .ready       (ready),
    .done        (done),
    .error       (error),
    .rdata       (rdata),
    .request     (request),
    .grant       (grant),
    .slave_select(slave_select),
    .bus_out     (bus_out),
    .bus_valid   (bus_valid),
    .bus_rw      (bus_rw),
    .bus_in      (bus_in),
    .bus_in_valid(bus_in_valid)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required finish earlier");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_frame(input logic r, input logic [SLV_W-1:0] sid,
                            input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] wd);
    logic [SLV_W-1:0]  s;
    logic [ADDR_W-1:0] t;
    logic [DATA_W-1:0] d;
    exp_sel_q.delete();
    exp_bus_q.delete();
    s = sid;
    t = a;
    d = wd;
    exp_sel_q.push_back(1'b1);
    for (int i = 0; i < SLV_W; i++) begin
      exp_sel_q.push_back(s[0]);
      s = s >> 1;
    end
    for (int i = 0; i < ADDR_W; i++) begin
      exp_bus_q.push_back(t[0]);
      t = t >> 1;
    end
    if (r == RW_WRITE) begin
      for (int i = 0; i < DATA_W; i++) begin
        exp_bus_q.push_back(d[0]);
        d = d >> 1;
      end
    end
  endtask

  task automatic issue(input logic r, input logic [SLV_W-1:0] sid, input logic [ADDR_W-1:0] a,
                       input logic [DATA_W-1:0] wd, input logic g);
    push_frame(r, sid, a, wd);
    rw       = r;
    slave_id = sid;
    addr     = a;
    wdata    = wd;
    start    = 1'b1;
    step();
    start = 1'b0;
    grant = g;
  endtask

  task automatic test_reset();
    checks++;
    if (ready !== 1'b1 || request !== 1'b0 || done !== 1'b0 || error !== 1'b0 || rdata !== '0 ||
        bus_valid !== 1'b0 || slave_select !== 1'b0 || bus_out !== 1'b0 || bus_rw !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: ready=%b req=%b done=%b err=%b rdata=%h bv=%b ss=%b, required 1 0 0 0 00 0 0",
               ready, request, done, error, rdata, bus_valid, slave_select);
    end
    reset = 1'b0;
    step();
    step();
    checks++;
    if (ready !== 1'b1 || request !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: ready=%b request=%b, required 1 0", ready, request);
    end
    $display("test_reset done");
  endtask

  task automatic test_write();
    int done_cyc;
    bit e;
    done_cyc = -1;
    issue(RW_WRITE, 2'b10, 12'hA5C, 8'h3C, 1'b1);
    checks++;
    if (request !== 1'b1 || ready !== 1'b0) begin
      errors++;
      $display("FAIL write_req: request=%b ready=%b, required 1 0", request, ready);
    end
    for (int c = 1; c <= WR_LAT + 4 && done_cyc < 0; c++) begin
      step();
      if (c <= SLV_W + 1) begin
        e = exp_sel_q.pop_front();
        checks++;
        if (slave_select !== e) begin
          errors++;
          $display("FAIL write_sel cycle %0d: slave_select=%b, required %b", c, slave_select, e);
        end
      end
      if (bus_valid === 1'b1) begin
        checks++;
        if (exp_bus_q.size() == 0) begin
          errors++;
          $display("FAIL write_bus_extra cycle %0d: bus_valid=1, required 0", c);
        end else begin
          e = exp_bus_q.pop_front();
          if (bus_out !== e || bus_rw !== 1'b1) begin
            errors++;
            $display("FAIL write_bus cycle %0d: bus_out=%b bus_rw=%b, required %b 1", c, bus_out, bus_rw, e);
          end
        end
      end
      if (done === 1'b1) done_cyc = c;
    end
    checks++;
    if (done_cyc != WR_LAT) begin
      errors++;
      $display("FAIL write_latency: done at %0d, required %0d", done_cyc, WR_LAT);
    end
    checks++;
    if (exp_bus_q.size() != 0) begin
      errors++;
      $display("FAIL write_bits_left: %0d bits not sent, required 0", exp_bus_q.size());
    end
    step();
    checks++;
    if (request !== 1'b0 || ready !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL write_after: request=%b ready=%b done=%b, required 0 1 0", request, ready, done);
    end
    $display("test_write: addr=a5c wdata=3c done_cycle=%0d", done_cyc);
  endtask

  task automatic test_read();
    bit seen_err;
    bit in_rwait;
    bit prev_valid;
    bit e;
    int k;
    logic [DATA_W-1:0] reply;
    logic [DATA_W-1:0] exp_rd;
    seen_err   = 1'b0;
    in_rwait   = 1'b0;
    prev_valid = 1'b0;
    reply      = 8'hC3;
    issue(RW_READ, 2'd1, 12'h001, 8'h00, 1'b1);
    for (int c = 1; c <= 40 && !in_rwait; c++) begin
      step();
      if (error === 1'b1) seen_err = 1'b1;
      if (bus_valid === 1'b1) begin
        checks++;
        e = exp_bus_q.pop_front();
        if (bus_out !== e || bus_rw !== 1'b0) begin
          errors++;
          $display("FAIL read_addr cycle %0d: bus_out=%b bus_rw=%b, required %b 0", c, bus_out, bus_rw, e);
        end
      end else if (prev_valid) begin
        in_rwait = 1'b1;
      end
      prev_valid = (bus_valid === 1'b1);
    end
    checks++;
    if (!in_rwait) begin
      errors++;
      $display("FAIL read_rwait: address phase end seen=0, required 1");
    end
    exp_rdata_q.push_back(reply);
    // Reply bits 0..4, three idle cycles, then bits 5..7.
    for (int s = 0; s < DATA_W + 3; s++) begin
      k = (s < 5) ? s : s - 3;
      bus_in_valid = (s < 5 || s >= 8);
      bus_in       = bus_in_valid ? reply[k[2:0]] : 1'b0;
      step();
      if (error === 1'b1) seen_err = 1'b1;
      checks++;
      if (done !== (s == DATA_W + 2)) begin
        errors++;
        $display("FAIL read_done_timing slot %0d: done=%b, required %b", s, done, (s == DATA_W + 2));
      end
    end
    bus_in_valid = 1'b0;
    bus_in       = 1'b0;
    exp_rd = exp_rdata_q.pop_front();
    last_rdata = exp_rd;
    checks++;
    if (rdata !== exp_rd) begin
      errors++;
      $display("FAIL read_data: rdata=%h, required %h", rdata, exp_rd);
    end
    step();
    checks++;
    if (seen_err || ready !== 1'b1) begin
      errors++;
      $display("FAIL read_clean: error_seen=%b ready=%b, required 0 1", seen_err, ready);
    end
    $display("test_read: rdata=%h expected=%h", rdata, exp_rd);
  endtask

  task automatic test_grant_timeout();
    int err_cyc;
    err_cyc = -1;
    issue(RW_WRITE, 2'd3, 12'h123, 8'h55, 1'b0);
    for (int c = 1; c <= TIMEOUT + 5 && err_cyc < 0; c++) begin
      step();
      if (error === 1'b1) begin
        err_cyc = c;
        checks++;
        if (request !== 1'b0) begin
          errors++;
          $display("FAIL gto_request: request=%b at error, required 0", request);
        end
      end
    end
    checks++;
    if (err_cyc != TIMEOUT) begin
      errors++;
      $display("FAIL gto_cycle: error at %0d, required %0d", err_cyc, TIMEOUT);
    end
    step();
    checks++;
    if (ready !== 1'b1 || error !== 1'b0) begin
      errors++;
      $display("FAIL gto_after: ready=%b error=%b, required 1 0", ready, error);
    end
    $display("test_grant_timeout: error_cycle=%0d", err_cyc);
  endtask

  task automatic test_preempt();
    int valid_cnt;
    int done_cyc;
    bit dropped;
    bit e;
    valid_cnt = 0;
    done_cyc  = -1;
    dropped   = 1'b0;
    issue(RW_WRITE, 2'b01, 12'h3C5, 8'hA7, 1'b1);
    for (int c = 1; c <= 40 && !dropped; c++) begin
      step();
      if (bus_valid === 1'b1) begin
        if (valid_cnt == 6) begin
          grant = 1'b0;
          #1;
          dropped = 1'b1;
          checks++;
          if (bus_valid !== 1'b0 || request !== 1'b1) begin
            errors++;
            $display("FAIL preempt_drop: bus_valid=%b request=%b, required 0 1", bus_valid, request);
          end
        end
        valid_cnt++;
      end
    end
    checks++;
    if (!dropped) begin
      errors++;
      $display("FAIL preempt_bit6: addr bit 6 seen=0, required 1");
    end
    for (int k = 0; k < 5; k++) begin
      step();
      checks++;
      if (bus_valid !== 1'b0 || slave_select !== 1'b0 || request !== 1'b1 || error !== 1'b0) begin
        errors++;
        $display("FAIL preempt_hold %0d: bv=%b ss=%b req=%b err=%b, required 0 0 1 0",
                 k, bus_valid, slave_select, request, error);
      end
    end
    push_frame(RW_WRITE, 2'b01, 12'h3C5, 8'hA7);
    grant = 1'b1;
    for (int c = 1; c <= WR_LAT + 4 && done_cyc < 0; c++) begin
      step();
      if (c <= SLV_W + 1) begin
        e = exp_sel_q.pop_front();
        checks++;
        if (slave_select !== e) begin
          errors++;
          $display("FAIL preempt_sel cycle %0d: slave_select=%b, required %b", c, slave_select, e);
        end
      end
      if (bus_valid === 1'b1 && exp_bus_q.size() > 0) begin
        e = exp_bus_q.pop_front();
        checks++;
        if (bus_out !== e) begin
          errors++;
          $display("FAIL preempt_bus cycle %0d: bus_out=%b, required %b", c, bus_out, e);
        end
      end
      if (done === 1'b1) done_cyc = c;
    end
    checks++;
    if (done_cyc != WR_LAT || exp_bus_q.size() != 0) begin
      errors++;
      $display("FAIL preempt_latency: done at %0d with %0d bits left, required %0d and 0",
               done_cyc, exp_bus_q.size(), WR_LAT);
    end
    step();
    $display("test_preempt: restart done_cycle=%0d", done_cyc);
  endtask

  task automatic test_read_timeout();
    int err_cyc;
    bit in_rwait;
    bit prev_valid;
    err_cyc    = -1;
    in_rwait   = 1'b0;
    prev_valid = 1'b0;
    issue(RW_READ, 2'd2, 12'h7F0, 8'h00, 1'b1);
    for (int c = 1; c <= 40 && !in_rwait; c++) begin
      step();
      if (bus_valid !== 1'b1 && prev_valid) in_rwait = 1'b1;
      prev_valid = (bus_valid === 1'b1);
    end
    checks++;
    if (!in_rwait) begin
      errors++;
      $display("FAIL rto_rwait: address phase end seen=0, required 1");
    end
    for (int c = 1; c <= TIMEOUT + 5 && err_cyc < 0; c++) begin
      step();
      if (error === 1'b1) err_cyc = c;
    end
    checks++;
    if (err_cyc != TIMEOUT) begin
      errors++;
      $display("FAIL rto_cycle: error at %0d, required %0d", err_cyc, TIMEOUT);
    end
    checks++;
    if (rdata !== last_rdata || request !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL rto_state: rdata=%h request=%b done=%b, required %h 0 0",
               rdata, request, done, last_rdata);
    end
    step();
    $display("test_read_timeout: error_cycle=%0d rdata=%h", err_cyc, rdata);
  endtask

  task automatic test_async_reset();
    int valid_cnt;
    int done_cyc;
    bit hit;
    valid_cnt = 0;
    done_cyc  = -1;
    hit       = 1'b0;
    issue(RW_WRITE, 2'b11, 12'hF0F, 8'h96, 1'b1);
    for (int c = 1; c <= 40 && !hit; c++) begin
      step();
      if (bus_valid === 1'b1) begin
        valid_cnt++;
        if (valid_cnt == ADDR_W + 3) hit = 1'b1;
      end
    end
    checks++;
    if (!hit) begin
      errors++;
      $display("FAIL arst_wdata: write data phase seen=0, required 1");
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (ready !== 1'b1 || request !== 1'b0 || done !== 1'b0 || error !== 1'b0 || rdata !== '0 ||
        bus_valid !== 1'b0 || bus_out !== 1'b0 || bus_rw !== 1'b0 || slave_select !== 1'b0) begin
      errors++;
      $display("FAIL arst_outputs: ready=%b req=%b done=%b err=%b rdata=%h bv=%b bo=%b brw=%b ss=%b, required 1 0 0 0 00 0 0 0 0",
               ready, request, done, error, rdata, bus_valid, bus_out, bus_rw, slave_select);
    end
    step();
    reset = 1'b0;
    last_rdata = '0;
    step();
    issue(RW_WRITE, 2'b00, 12'h0F1, 8'h5A, 1'b1);
    for (int c = 1; c <= WR_LAT + 4 && done_cyc < 0; c++) begin
      step();
      if (done === 1'b1) done_cyc = c;
    end
    checks++;
    if (done_cyc != WR_LAT || rdata !== last_rdata) begin
      errors++;
      $display("FAIL arst_restart: done at %0d rdata=%h, required %0d %h", done_cyc, rdata, WR_LAT, last_rdata);
    end
    step();
    $display("test_async_reset: post-reset done_cycle=%0d", done_cyc);
  endtask

  initial begin
    reset        = 1'b1;
    start        = 1'b0;
    rw           = 1'b0;
    slave_id     = '0;
    addr         = '0;
    wdata        = '0;
    grant        = 1'b0;
    bus_in       = 1'b0;
    bus_in_valid = 1'b0;
    last_rdata   = '0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    test_write();
    test_read();
    test_grant_timeout();
    test_preempt();
    test_read_timeout();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bus_master_port.md
Name: bus_master_port

Overview:
- Master-side bus interface sitting directly upstream of the system bus arbiter.
- Accepts a parallel read/write command from a core and raises the arbiter request.
- After grant: serializes a slave-select frame, the address and (for writes) write data onto the serial bus, then (for reads) deserializes the slave's reply.
- Handles grant loss (preemption) by retrying, and timeouts by aborting.

Parameters:
- ADDR_W, 12, address width in bits
- DATA_W, 8, data width in bits
- SLV_W, 2, slave id width in bits
- TIMEOUT, 255, max idle wait cycles for grant or read reply before abort

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  core command strobe; sampled only when ready=1
- rw  in  1  1=write, 0=read; captured with start
- slave_id  in  SLV_W  target slave; captured with start
- addr  in  ADDR_W  target address; captured with start
- wdata  in  DATA_W  write data; captured with start
- ready  out  1  port idle, command accepted
- done  out  1  one-cycle pulse, transaction completed
- error  out  1  one-cycle pulse, transaction aborted by timeout
- rdata  out  DATA_W  read result; valid from done, held until next read's done
- request  out  1  arbiter request
- grant  in  1  arbiter grant to this master
- slave_select  out  1  serial slave-select frame
- bus_out  out  1  serial address/write data, LSB first
- bus_valid  out  1  bus_out carries a valid bit
- bus_rw  out  1  captured rw; valid while bus_valid=1
- bus_in  in  1  serial read data from slave, LSB first
- bus_in_valid  in  1  bus_in carries a valid bit

Behaviour:
- Reset: async. State IDLE, ready=1, all other outputs 0, rdata=0, counters 0.
- IDLE: start=1 at an edge captures rw/slave_id/addr/wdata and moves to REQ. At that edge request=1 and ready=0.
- REQ: request held at 1; wait counter increments each cycle.
  - grant=1 sampled: go to SEL and clear the counter.
  - Counter reaches TIMEOUT: error pulse, request=0, go to IDLE.
- SEL: drives SLV_W+1 cycles on slave_select: a start bit '1', then slave_id LSB first. slave_select is 0 in all other states. Then go to ADDR.
- ADDR: ADDR_W cycles. bus_valid=1, bus_out=addr bit i in cycle i. bus_rw=rw.
  - Then go to WDATA if write, else RWAIT.
- WDATA: DATA_W cycles; bus_valid=1, bus_out=wdata LSB first. Then go to DONE.
- RWAIT: bus_valid=0. Each cycle with bus_in_valid=1 shifts bus_in into rdata_shift at bit position k (LSB first).
  - After DATA_W sampled bits: rdata<=shift, go to DONE.
  - Gaps in bus_in_valid are allowed; the timeout counter runs only while bus_in_valid=0 and resets on each valid bit.
  - Timeout: error pulse, request=0, rdata unchanged, go to IDLE.
- DONE: one cycle. done=1, request=0, ready returns to 1 at the next edge (IDLE).
- Write latency: done asserts SLV_W+1+ADDR_W+DATA_W+1 cycles after the edge grant is first sampled. Defaults: 24 cycles.
- Grant loss: grant=0 sampled in SEL/ADDR/WDATA/RWAIT means preemption.
  - Abort the current frame: bus_valid=0, slave_select=0, bit counter cleared, read shift cleared.
  - Return to REQ with request held at 1. The whole transaction restarts from SEL on re-grant. No error.
- bus_in_valid outside RWAIT is ignored. start while ready=0 is ignored, with no queueing.
- Bit counter width: clog2(max(ADDR_W, DATA_W, SLV_W+1)). No wrap; it is cleared at every state entry.
- Reset mid-transaction: immediate return to reset values. No done/error pulse.

Decomposition:
- Package bus_pkg: state enum (IDLE, REQ, SEL, ADDR, WDATA, RWAIT, DONE), default widths, the RW_WRITE/RW_READ constants.
- One sub-module, bus_shift_reg: parameterized width; parallel load, shift-out LSB first, shift-in LSB first, clear. Instantiated once for the TX path (addr then wdata reload) and once for RX.

Test Plan:
1. Write: start, rw=1, slave_id=2'b10, addr=12'hA5C, wdata=8'h3C, grant held high from the cycle after request.
   - slave_select sequence 1,0,1.
   - bus_out shows 0x A5C LSB first (0,0,1,1,1,0,1,0,0,1,0,1), then 0x3C LSB first.
   - done exactly 24 cycles after grant sampled; request low after done.
2. Read: start, rw=0, slave_id=1, addr=12'h001. Slave returns 8'hC3 with 3 idle cycles inserted after bit 4.
   - rdata=8'hC3 at done; error never asserted.
3. Grant timeout: grant tied 0.
   - error pulse exactly TIMEOUT cycles after entering REQ; request=0; ready=1 next cycle.
4. Preemption: drop grant for 5 cycles during ADDR bit 6.
   - bus_valid=0 while grant is low; request stays 1.
   - On re-grant, the full frame restarts with start bit and addr bit 0.
   - Done arrives 24 cycles after re-grant.
5. Read timeout: no bus_in_valid after address.
   - error after TIMEOUT cycles; rdata retains the previous value (8'hC3).
6. Async reset asserted mid-WDATA.
   - All outputs 0 and ready=1 immediately, without a clock edge.
   - A new start after reset completes normally.
